// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared sprite types, kick states and geometry constants
package sprite_pkg;

    localparam int H_SIZE     = 32;
    localparam int V_SIZE     = 32;
    localparam int FRAME_SIZE = H_SIZE * V_SIZE;
    localparam int SPR_ADDR_W = 11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        KICK     = 2'd1,
        COOLDOWN = 2'd2
    } kick_state_t;

    typedef struct packed {
        logic [SPR_ADDR_W-1:0] addr;
        logic [2:0]            data;
    } sprite_wr_t;

endpackage

// File: rtl/sprite_wr_fifo.sv
// rtl/sprite_wr_fifo.sv - synchronous write FIFO with occupancy count
module sprite_wr_fifo
    import sprite_pkg::*;
#(
    parameter int  DEPTH = 16,
    parameter type T     = sprite_wr_t
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_push,
    input  T                     i_data,
    input  logic                 i_pop,
    output T                     o_data,
    output logic                 o_full,
    output logic                 o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PW = $clog2(DEPTH);

    T                r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW:0]     r_count;
    logic            w_push;
    logic            w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == (PW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/player_sprite_ctrl.sv
// rtl/player_sprite_ctrl.sv - kick animation sequencer and vblank-gated sprite RAM write scheduler
// Optional: PLAYER_KICK_QUEUE_EN queues one kick request received while a kick is in progress.
module player_sprite_ctrl
    import sprite_pkg::*;
#(
    parameter int ADDR            = 11,
    parameter int KICK_FRAMES     = 8,
    parameter int COOLDOWN_FRAMES = 16,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          vblank,
    input  logic                          kick_req,
    input  logic                          wr_valid,
    input  logic [ADDR-1:0]               wr_addr,
    input  logic [2:0]                    wr_data,
    output logic                          wr_ready,
    output logic                          sel,
    output logic                          busy,
    output logic                          ram_we,
    output logic [ADDR-1:0]               ram_addr,
    output logic [2:0]                    ram_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    typedef struct packed {
        logic [ADDR-1:0] addr;
        logic [2:0]      data;
    } wr_entry_t;

    localparam logic [7:0] KICK_LD = 8'(KICK_FRAMES - 1);
    localparam logic [7:0] COOL_LD = (COOLDOWN_FRAMES == 0) ? 8'd0 : 8'(COOLDOWN_FRAMES - 1);

    kick_state_t     r_state;
    logic [7:0]      r_fcnt;
    logic            r_pending;
    logic            r_vblank_q;
    logic            r_sel;
    logic            r_busy;
    logic            r_ram_we;
    logic [ADDR-1:0] r_ram_addr;
    logic [2:0]      r_ram_data;

    logic            w_tick;
    logic            w_kick_q;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    wr_entry_t       w_in;
    wr_entry_t       w_head;

`ifdef PLAYER_KICK_QUEUE_EN
    assign w_kick_q = kick_req;
`else
    assign w_kick_q = 1'b0;
`endif

    assign w_tick   = vblank && !r_vblank_q;
    assign wr_ready = !w_full && !reset;
    assign w_push   = wr_valid && wr_ready;
    assign w_pop    = vblank && !w_empty;
    assign w_in.addr = wr_addr;
    assign w_in.data = wr_data;

    sprite_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (wr_entry_t)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_in),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    // A request on the very tick that serves a pending kick merges into it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_fcnt     <= 8'd0;
            r_pending  <= 1'b0;
            r_vblank_q <= 1'b0;
            r_sel      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_vblank_q <= vblank;
            case (r_state)
                IDLE: begin
                    if (w_tick && r_pending) begin
                        r_state   <= KICK;
                        r_fcnt    <= KICK_LD;
                        r_pending <= 1'b0;
                        r_sel     <= 1'b1;
                        r_busy    <= 1'b1;
                    end else if (kick_req) begin
                        r_pending <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                KICK: begin
                    if (w_kick_q) r_pending <= 1'b1;
                    if (w_tick) begin
                        if (r_fcnt == 8'd0) begin
                            r_sel <= 1'b0;
                            if (COOLDOWN_FRAMES == 0) begin
                                r_state <= IDLE;
                                r_busy  <= r_pending || w_kick_q;
                            end else begin
                                r_state <= COOLDOWN;
                                r_fcnt  <= COOL_LD;
                            end
                        end else begin
                            r_fcnt <= r_fcnt - 8'd1;
                        end
                    end
                end
                COOLDOWN: begin
                    if (w_kick_q) r_pending <= 1'b1;
                    if (w_tick) begin
                        if (r_fcnt == 8'd0) begin
                            r_state <= IDLE;
                            r_busy  <= r_pending || w_kick_q;
                        end else begin
                            r_fcnt <= r_fcnt - 8'd1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_sel   <= 1'b0;
                    r_busy  <= r_pending;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ram_we   <= 1'b0;
            r_ram_addr <= '0;
            r_ram_data <= 3'd0;
        end else begin
            r_ram_we <= w_pop;
            if (w_pop) begin
                r_ram_addr <= w_head.addr;
                r_ram_data <= w_head.data;
            end
        end
    end

    assign sel      = r_sel;
    assign busy     = r_busy;
    assign ram_we   = r_ram_we;
    assign ram_addr = r_ram_addr;
    assign ram_data = r_ram_data;

endmodule

// File: tb/tb_player_sprite_ctrl.sv
// tb/tb_player_sprite_ctrl.sv - self-checking bench for player_sprite_ctrl
module tb_player_sprite_ctrl;

    localparam int ADDR = 11;
    localparam int K    = 8;
    localparam int C    = 16;
    localparam int D    = 16;
`ifdef PLAYER_KICK_QUEUE_EN
    localparam bit QUEUE = 1'b1;
`else
    localparam bit QUEUE = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            vblank;
    logic            kick_req;
    logic            wr_valid;
    logic [ADDR-1:0] wr_addr;
    logic [2:0]      wr_data;
    logic            wr_ready;
    logic            sel;
    logic            busy;
    logic            ram_we;
    logic [ADDR-1:0] ram_addr;
    logic [2:0]      ram_data;
    logic [4:0]      fifo_count;

    int errors = 0;
    int checks = 0;

    player_sprite_ctrl #(
        .ADDR(ADDR), .KICK_FRAMES(K), .COOLDOWN_FRAMES(C), .FIFO_DEPTH(D)
    ) dut (
        .clk(clk), .reset(reset), .vblank(vblank), .kick_req(kick_req),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .sel(sel), .busy(busy), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_data(ram_data), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a kick is "active" for K+C ticks counted from its start tick;
    // sel is high for the first K of them. FIFO is a plain queue.
    bit          m_vb_q;
    bit          m_active;
    int          m_ts;
    bit          m_pend;
    logic [13:0] m_q[$];
    bit          exp_sel, exp_busy, exp_we, exp_ready;
    logic [ADDR-1:0] exp_addr;
    logic [2:0]  exp_data;
    bit          s_reset;

    always begin
        bit tick, idle_before, started, pop, push;
        logic [13:0] e;
        @(posedge clk);
        s_reset = reset;
        if (reset) begin
            m_vb_q = 0; m_active = 0; m_ts = 0; m_pend = 0;
            m_q.delete();
            exp_sel = 0; exp_busy = 0; exp_we = 0; exp_addr = '0; exp_data = '0;
        end else begin
            tick = vblank && !m_vb_q;
            m_vb_q = vblank;
            idle_before = !m_active;
            started = 0;
            if (tick) begin
                if (m_active) begin
                    m_ts++;
                    if (m_ts == K + C) m_active = 0;
                end else if (m_pend) begin
                    m_active = 1; m_ts = 0; m_pend = 0; started = 1;
                end
            end
            if (kick_req && (idle_before || QUEUE) && !started) m_pend = 1;
            exp_sel  = m_active && (m_ts < K);
            exp_busy = m_active || m_pend;
            pop  = vblank && (m_q.size() > 0);
            push = wr_valid && (m_q.size() < D);
            if (pop) begin
                e = m_q.pop_front();
                exp_we = 1; exp_addr = e[13:3]; exp_data = e[2:0];
            end else begin
                exp_we = 0;
            end
            if (push) m_q.push_back({wr_addr, wr_data});
        end
        exp_ready = !s_reset && (m_q.size() < D);
        #2;
        check("sel", sel, exp_sel);
        check("busy", busy, exp_busy);
        check("ram_we", ram_we, exp_we);
        check("fifo_count", fifo_count, m_q.size());
        check("wr_ready", wr_ready, exp_ready);
        if (exp_we || s_reset) begin
            check("ram_addr", ram_addr, exp_addr);
            check("ram_data", ram_data, exp_data);
        end
    end

    task automatic cycle();
        @(negedge clk);
    endtask

    task automatic push_one(input logic [ADDR-1:0] a, input logic [2:0] d);
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        cycle();
        wr_valid = 1'b0;
    endtask

    task automatic frame(output bit s, output bit b);
        vblank = 1'b0;
        repeat (6) cycle();
        vblank = 1'b1;
        cycle();
        s = sel; b = busy;
        repeat (3) cycle();
        vblank = 1'b0;
    endtask

    bit              sel_at [30];
    bit              busy_at [30];
    logic [ADDR-1:0] a_exp [16];
    int              n;
    int              idx;
    int              vb_cnt;
    bit              s_tmp, b_tmp;

    initial begin
        reset = 1'b1; vblank = 1'b0; kick_req = 1'b0; wr_valid = 1'b0;
        wr_addr = '0; wr_data = '0;
        repeat (3) cycle();
        check("reset_sel", sel, 0);
        check("reset_busy", busy, 0);
        check("reset_count", fifo_count, 0);
        check("reset_ready", wr_ready, 0);
        reset = 1'b0;
        cycle();
        check("ready_after_reset", wr_ready, 1);

        // kick waits for the first vblank rise
        kick_req = 1'b1; cycle(); kick_req = 1'b0;
        repeat (100) cycle();
        check("kick_wait_sel", sel, 0);
        check("kick_wait_busy", busy, 1);
        for (int f = 0; f < 30; f++) begin
            frame(sel_at[f], busy_at[f]);
            if (f == 3) begin
                kick_req = 1'b1; cycle(); kick_req = 1'b0;
            end
        end
        n = 0;
        for (int f = 0; f < 25; f++) n += int'(sel_at[f]);
        check("kick_sel_ticks", n, K);
        check("kick_f0_sel", sel_at[0], 1);
        check("kick_f7_sel", sel_at[7], 1);
        check("kick_f8_sel", sel_at[8], 0);
        check("kick_f23_busy", busy_at[23], 1);
        check("kick_f24_busy", busy_at[24], QUEUE);
        check("kick_f25_sel", sel_at[25], QUEUE);

        // fill FIFO and drain in one blanking interval
        for (int i = 0; i < 16; i++) begin
            a_exp[i] = ADDR'($urandom);
            push_one(a_exp[i], 3'($urandom));
        end
        check("full_count", fifo_count, 16);
        check("full_ready", wr_ready, 0);
        vblank = 1'b1;
        cycle();
        check("drain_first_we", ram_we, 1);
        check("drain_first_addr", ram_addr, a_exp[0]);
        idx = 1;
        repeat (19) begin
            cycle();
            if (ram_we) begin
                if (idx < 16) check("drain_addr", ram_addr, a_exp[idx]);
                idx++;
            end
        end
        check("drain_writes", idx, 16);
        check("drain_count", fifo_count, 0);
        vblank = 1'b0;
        cycle();

        // short blanking drains partially
        for (int i = 0; i < 10; i++) push_one(ADDR'($urandom), 3'($urandom));
        n = 0;
        vblank = 1'b1;
        repeat (5) begin cycle(); n += int'(ram_we); end
        vblank = 1'b0;
        cycle(); n += int'(ram_we);
        check("short_vb_writes", n, 5);
        check("short_vb_count", fifo_count, 5);
        repeat (4) cycle();
        n = 0;
        vblank = 1'b1;
        repeat (10) begin cycle(); n += int'(ram_we); end
        vblank = 1'b0;
        check("second_vb_writes", n, 5);
        check("second_vb_count", fifo_count, 0);

        // reset mid-kick with entries queued
        kick_req = 1'b1; cycle(); kick_req = 1'b0;
        frame(s_tmp, b_tmp);
        for (int i = 0; i < 7; i++) push_one(ADDR'($urandom), 3'($urandom));
        check("pre_reset_count", fifo_count, 7);
        reset = 1'b1;
        cycle();
        check("midreset_sel", sel, 0);
        check("midreset_busy", busy, 0);
        check("midreset_count", fifo_count, 0);
        check("midreset_we", ram_we, 0);
        reset = 1'b0;
        cycle();
        n = 0;
        vblank = 1'b1;
        repeat (10) begin cycle(); n += int'(ram_we); end
        vblank = 1'b0;
        check("no_stale_writes", n, 0);

        // simultaneous push and pop, then pointer wrap
        for (int i = 0; i < 4; i++) push_one(ADDR'(100 + i), 3'(i));
        check("pp_count_before", fifo_count, 4);
        vblank = 1'b1; wr_valid = 1'b1; wr_addr = ADDR'(200); wr_data = 3'd5;
        cycle();
        vblank = 1'b0; wr_valid = 1'b0;
        check("pp_count_after", fifo_count, 4);
        check("pp_first_addr", ram_addr, 100);
        for (int i = 0; i < 40; i++) begin
            push_one(ADDR'($urandom), 3'($urandom));
            if (i % 5 == 4) begin
                vblank = 1'b1; repeat (3) cycle(); vblank = 1'b0;
            end
        end
        vblank = 1'b1; repeat (50) cycle(); vblank = 1'b0;
        cycle();
        check("wrap_drained", fifo_count, 0);

        // randomized traffic against the model
        vb_cnt = 0;
        for (int c = 0; c < 4000; c++) begin
            if (vb_cnt == 0) begin
                vblank = !vblank;
                vb_cnt = vblank ? int'($urandom_range(1, 6)) : int'($urandom_range(2, 12));
            end
            vb_cnt--;
            kick_req = ($urandom_range(0, 19) == 0);
            wr_valid = ($urandom_range(0, 2) != 0);
            wr_addr  = ADDR'($urandom);
            wr_data  = 3'($urandom);
            reset    = ($urandom_range(0, 799) == 0);
            cycle();
        end
        reset = 1'b0; vblank = 1'b0; kick_req = 1'b0; wr_valid = 1'b0;
        repeat (5) cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
